// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM carrier generator and the downstream dead-time stage.
package pwm_pkg;

  // Default counter/period/duty width, shared with the dead-time stage.
  localparam int PWM_N = 12;

  // Carrier alignment mode.
  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Carrier counter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_shadow_regs.sv
// Double-buffered configuration register: one pending slot filled through a
// valid/ready handshake, copied into the active slot when 'apply' is high.
// Generic in width so it can also buffer the dead-time value.
module pwm_shadow_regs
  import pwm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [W-1:0] load_data,
  input  logic         apply,
  output logic [W-1:0] act_data
);

  logic         pend_full_q, pend_full_d;
  logic [W-1:0] pend_q, pend_d;
  logic [W-1:0] act_q, act_d;
  logic         accept;
  logic         apply_now;

  assign load_ready = ~pend_full_q;
  assign act_data   = act_q;

  // Accept into the pending slot only when empty; drain it into active on apply.
  // Because acceptance needs an empty slot, an accept and an apply never
  // coincide, so an apply always moves the set that was already pending.
  always_comb begin
    accept      = load_valid & ~pend_full_q;
    apply_now   = apply & pend_full_q;
    pend_d      = pend_q;
    act_d       = act_q;
    pend_full_d = pend_full_q;
    if (apply_now) begin
      act_d       = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = load_data;
      pend_full_d = 1'b1;
    end
  end

  // Pending/active storage; reset discards any pending set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      act_q       <= '0;
    end else begin
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
    end
  end

endmodule

// File: rtl/pwm_carrier_gen.sv
// Single-channel PWM carrier: free-running edge/center-aligned counter compared
// against a double-buffered duty value to give a raw PWM for the dead-time stage.
module pwm_carrier_gen
  import pwm_pkg::*;
#(
  parameter int N = PWM_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] period,
  input  logic [N-1:0] duty,
  input  logic         center_mode,
  output logic         pwm_out,
  output logic         period_start,
  output logic [N-1:0] cnt_out
);

  localparam int          CFG_W = 2 * N + 1;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [CFG_W-1:0] cfg_act;
  logic [N-1:0]     period_act;
  logic [N-1:0]     duty_act;
  pwm_mode_e        mode_act;
  logic             boundary;

  pwm_state_e   state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         pwm_q, pwm_d;
  logic         pstart_q, pstart_d;

  pwm_shadow_regs #(
    .W(CFG_W)
  ) u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  ({period, duty, center_mode}),
    .apply      (boundary),
    .act_data   (cfg_act)
  );

  assign period_act = cfg_act[CFG_W-1 -: N];
  assign duty_act   = cfg_act[N:1];
  assign mode_act   = pwm_mode_e'(cfg_act[0]);

  assign pwm_out      = pwm_q;
  assign period_start = pstart_q;
  assign cnt_out      = cnt_q;

  // Next counter/state; 'boundary' marks the cycles where new settings may land
  // (counter wrapping to 0, or carrier stopped).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    if (!enable) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      boundary = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_UP;
          cnt_d   = '0;
        end
        ST_UP: begin
          if (period_act == '0) begin
            // Degenerate period: counter parks at 0 and every cycle restarts.
            cnt_d    = '0;
            boundary = 1'b1;
          end else if (cnt_q >= period_act) begin
            // Period 1 in center mode is just 0,1 -- no distinct down ramp.
            if (mode_act == PWM_CENTER && period_act > ONE) begin
              state_d = ST_DOWN;
              cnt_d   = cnt_q - ONE;
            end else begin
              cnt_d    = '0;
              boundary = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        ST_DOWN: begin
          if (cnt_q <= ONE) begin
            state_d  = ST_UP;
            cnt_d    = '0;
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Compare and period-start flags; gating with enable gives an abrupt stop.
  always_comb begin
    pwm_d    = enable & (state_q != ST_IDLE) & (cnt_q < duty_act);
    pstart_d = (state_d == ST_UP) & (cnt_d == '0);
  end

  // Carrier FSM, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pwm_q    <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
      pstart_q <= pstart_d;
    end
  end

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Directed bench for pwm_carrier_gen: table of carrier settings with
// hand-computed period length / high time / peak count, plus sequences for
// double buffering, enable drop and asynchronous reset.
module tb_pwm_carrier_gen;
  import pwm_pkg::*;

  localparam int N  = PWM_N;
  localparam int NV = 11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         load_valid;
  logic         load_ready;
  logic [N-1:0] period;
  logic [N-1:0] duty;
  logic         center_mode;
  logic         pwm_out;
  logic         period_start;
  logic [N-1:0] cnt_out;

  int checks   = 0;
  int failures = 0;

  pwm_carrier_gen #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .period       (period),
    .duty         (duty),
    .center_mode  (center_mode),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .cnt_out      (cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] p;
    logic [N-1:0] d;
    logic         c;
    int           len;
    int           high;
    int           maxc;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mk(input int p, input int d, input int c,
                              input int len, input int high, input int maxc);
    vec_t v;
    v.p    = N'(p);
    v.d    = N'(d);
    v.c    = (c != 0);
    v.len  = len;
    v.high = high;
    v.maxc = maxc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Sync to a period_start, then measure one full period starting there.
  task automatic measure(output int len, output int highs, output int maxc);
    int n;
    n = 0;
    while (!period_start && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("measure_sync", int'(period_start), 1);
    len   = 0;
    highs = 0;
    maxc  = 0;
    do begin
      highs += int'(pwm_out);
      if (int'(cnt_out) > maxc) maxc = int'(cnt_out);
      len++;
      @(negedge clk);
    end while (!period_start && len < 300);
  endtask

  // Offer a configuration and hold it until accepted; returns on a negedge.
  task automatic load_cfg(input int p, input int d, input int c);
    int n;
    n           = 0;
    period      = N'(p);
    duty        = N'(d);
    center_mode = (c != 0);
    load_valid  = 1'b1;
    while (!load_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("load_accept", int'(load_ready), 1);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int l, h, m, h1, h2, h3, n;

    //          period duty center len high max
    vecs[0]  = mk(9,    3,   0,     10, 3,   9);
    vecs[1]  = mk(8,    2,   1,     16, 3,   8);
    vecs[2]  = mk(9,    0,   0,     10, 0,   9);
    vecs[3]  = mk(9,    10,  0,     10, 10,  9);
    vecs[4]  = mk(8,    9,   1,     16, 16,  8);
    vecs[5]  = mk(8,    8,   1,     16, 15,  8);
    vecs[6]  = mk(0,    0,   0,     1,  0,   0);
    vecs[7]  = mk(0,    1,   1,     1,  1,   0);
    vecs[8]  = mk(1,    1,   1,     2,  1,   1);
    vecs[9]  = mk(5,    5,   0,     6,  5,   5);
    vecs[10] = mk(3,    2,   1,     6,  3,   3);

    rst_n       = 1'b1;
    enable      = 1'b0;
    load_valid  = 1'b0;
    period      = '0;
    duty        = '0;
    center_mode = 1'b0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_cnt_out", int'(cnt_out), 0);
    chk("rst_period_start", int'(period_start), 0);
    chk("rst_load_ready", int'(load_ready), 1);
    $display("reset: pwm=%0d cnt=%0d pstart=%0d ready=%0d", pwm_out, cnt_out, period_start, load_ready);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of carrier settings
    for (int i = 0; i < NV; i++) begin
      enable = 1'b0;
      @(negedge clk);
      load_cfg(int'(vecs[i].p), int'(vecs[i].d), int'(vecs[i].c));
      @(negedge clk);
      @(negedge clk);
      enable = 1'b1;
      measure(l, h, m);
      measure(l, h, m);
      chk($sformatf("v%0d_len", i), l, vecs[i].len);
      chk($sformatf("v%0d_high", i), h, vecs[i].high);
      chk($sformatf("v%0d_max", i), m, vecs[i].maxc);
      $display("vec %0d: period=%0d duty=%0d center=%0d len=%0d high=%0d max=%0d",
               i, vecs[i].p, vecs[i].d, vecs[i].c, l, h, m);
    end

    // Double buffer: duty 3 -> 7 mid-period, then a stalled second load of 5
    enable = 1'b0;
    @(negedge clk);
    load_cfg(9, 3, 0);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    while (!period_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("db_sync", int'(period_start), 1);
    h1 = 0;
    h2 = 0;
    h3 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k <= 10) h1 += int'(pwm_out);
      else if (k <= 20) h2 += int'(pwm_out);
      else h3 += int'(pwm_out);
      if (k == 2) begin
        period      = N'(9);
        duty        = N'(7);
        center_mode = 1'b0;
        load_valid  = 1'b1;
      end
      if (k == 3) begin
        chk("db_ready_after_accept", int'(load_ready), 0);
        duty = N'(5);
      end
      if (k == 9) chk("db_second_load_stalls", int'(load_ready), 0);
      if (k == 10) begin
        chk("db_boundary_pstart", int'(period_start), 1);
        chk("db_ready_at_boundary", int'(load_ready), 1);
      end
      if (k == 11) load_valid = 1'b0;
    end
    chk("db_high_old", h1, 3);
    chk("db_high_new", h2, 7);
    chk("db_high_second", h3, 5);
    $display("double-buffer: highs per period %0d %0d %0d", h1, h2, h3);

    // Enable drop mid-UP, load while idle, restart with new values
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("ed_cnt_zero", int'(cnt_out), 0);
    chk("ed_pwm_zero", int'(pwm_out), 0);
    chk("ed_pstart_zero", int'(period_start), 0);
    load_cfg(4, 2, 1);
    @(negedge clk);
    chk("ed_applied_while_idle", int'(load_ready), 1);
    enable = 1'b1;
    @(negedge clk);
    chk("ed_restart_pstart", int'(period_start), 1);
    chk("ed_restart_cnt", int'(cnt_out), 0);
    measure(l, h, m);
    measure(l, h, m);
    chk("ed_len", l, 8);
    chk("ed_high", h, 3);
    chk("ed_max", m, 4);
    $display("enable-drop restart: len=%0d high=%0d max=%0d", l, h, m);

    // Asynchronous reset mid-run discards a pending set
    period      = N'(9);
    duty        = N'(3);
    center_mode = 1'b0;
    load_valid  = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    chk("rr_pending_held", int'(load_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_pwm_out", int'(pwm_out), 0);
    chk("rr_cnt_out", int'(cnt_out), 0);
    chk("rr_load_ready", int'(load_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    measure(l, h, m);
    measure(l, h, m);
    chk("rr_len_after", l, 1);
    chk("rr_high_after", h, 0);
    chk("rr_max_after", m, 0);
    $display("mid-run reset: len=%0d high=%0d max=%0d", l, h, m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
